// File: rtl/turing_pkg.sv
// Handshake state encoding shared by the start/finished iterative blocks (Shifter, Normalizer).
package turing_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } hs_state_e;

endpackage

// File: rtl/normalizer_step.sv
// One combinational normalization step: left shift by one and the stop flag.
// NORMALIZER_SIGNED_EN selects the two's-complement stop rule (sign differs from next bit).
module normalizer_step #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] work,
  output logic [N-1:0] shifted,
  output logic         stop
);

  assign shifted = {work[N-2:0], 1'b0};

`ifdef NORMALIZER_SIGNED_EN
  assign stop = work[N-1] ^ work[N-2];
`else
  assign stop = work[N-1];
`endif

endmodule

// File: rtl/normalizer.sv
// Iterative left-normalizer: shifts the operand left one bit per cycle until normalized and
// reports the shift count. Build macro NORMALIZER_SIGNED_EN enables two's-complement mode.
module normalizer
  import turing_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_start,
  output logic          o_finished,
  input  logic [N-1:0]  i_value,
  output logic [N-1:0]  o_value,
  output logic [CW-1:0] o_count,
  output logic          o_zero
);

  localparam logic [CW-1:0] CntMax = CW'(N - 1);

  hs_state_e     state_q, state_d;
  logic [N-1:0]  work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  value_q, value_d;
  logic [CW-1:0] count_q, count_d;
  logic          zero_q, zero_d;

  logic [N-1:0]  shifted;
  logic          stop;

  normalizer_step #(
    .N(N)
  ) u_step (
    .work   (work_q),
    .shifted(shifted),
    .stop   (stop)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    count_d = count_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          work_d  = i_value;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (work_q == '0) begin
          value_d = '0;
          count_d = '0;
          zero_d  = 1'b1;
          state_d = StDone;
        end else if (stop || (cnt_q == CntMax)) begin
          value_d = work_q;
          count_d = cnt_q;
          zero_d  = 1'b0;
          state_d = StDone;
        end else begin
          work_d = shifted;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      StDone: begin
        // A held request must drop before the next operation can be accepted.
        if (!i_start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign o_finished = (state_q == StDone);
  assign o_value    = value_q;
  assign o_count    = count_q;
  assign o_zero     = zero_q;

endmodule
